// File: rtl/fft_r22sdf_ctrl_if.sv
// Control bus of the R2^2 SDF FFT sequencer: stream handshake in, datapath controls out.
interface fft_r22sdf_ctrl_if #(
  parameter int NLOG2 = 6
) ();
  localparam int NSTAGE = NLOG2 / 2;
  localparam int TW_W   = (NSTAGE - 1) * NLOG2;

  logic              start_i;
  logic              valid_i;
  logic              last_i;
  logic              dp_rst_n_o;
  logic [NSTAGE-1:0] bfi_sel_o;
  logic [NSTAGE-1:0] bfii_sel_o;
  logic [NSTAGE-1:0] bfii_tsel_o;
  logic [TW_W-1:0]   tw_addr_o;
  logic              dp_din_zero_o;
  logic              valid_o;
  logic [NLOG2-1:0]  index_o;
  logic              busy_o;
  logic              err_o;

  modport slave (
    input  start_i, valid_i, last_i,
    output dp_rst_n_o, bfi_sel_o, bfii_sel_o, bfii_tsel_o, tw_addr_o,
           dp_din_zero_o, valid_o, index_o, busy_o, err_o
  );

  modport master (
    output start_i, valid_i, last_i,
    input  dp_rst_n_o, bfi_sel_o, bfii_sel_o, bfii_tsel_o, tw_addr_o,
           dp_din_zero_o, valid_o, index_o, busy_o, err_o
  );
endinterface

// File: rtl/fft_r22sdf_ctrl.sv
// Sequencer for a streaming radix-2^2 SDF FFT: stage selects, twiddle addresses, fill/drain, bin index.
// Define FFT_R22SDF_CTRL_BITREV_EN to report index_o as the bit-reversed (true frequency) bin.
module fft_r22sdf_ctrl #(
  parameter int NLOG2  = 6,
  parameter int TW_LAT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fft_r22sdf_ctrl_if.slave ctl
);

  localparam int N         = 1 << NLOG2;
  localparam int NSTAGE    = NLOG2 / 2;
  localparam int TW_W      = (NSTAGE - 1) * NLOG2;
  localparam int TOTAL_LAT = (N - 1) + (NSTAGE - 1) * TW_LAT;
  localparam int LAT_W     = $clog2(TOTAL_LAT + 1);

  localparam logic [NLOG2-1:0] CTR_MAX    = NLOG2'(N - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(TOTAL_LAT);
  localparam logic [LAT_W-1:0] DRAIN_LOAD = LAT_W'(TOTAL_LAT - 1);

  // state | meaning
  // IDLE  | waiting for start_i & valid_i, datapath held quiet
  // RUN   | accepting whole frames of input samples
  // DRAIN | feeding zeros until the last frame has left the pipeline
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic              w_start, w_abort, w_to_drain, w_active_nxt;
  logic [NLOG2-1:0]  r_ctr, w_ctr_nxt;
  logic [LAT_W-1:0]  r_lat_cnt, w_lat_cnt_nxt;
  logic [LAT_W-1:0]  r_drain_cnt, w_drain_cnt_nxt;
  logic [NLOG2-1:0]  r_k, w_k_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_err, w_err_nxt;
  logic              r_dp_rst_n, w_dp_rst_n_nxt;
  logic [NSTAGE-1:0] r_bfi, r_bfii, r_tsel;
  logic [NSTAGE-1:0] w_bfi_nxt, w_bfii_nxt, w_tsel_nxt;
  logic [TW_W-1:0]   r_tw, w_tw_nxt;
  logic [NLOG2-1:0]  w_index;

  // Exponent of W_N for stage s: group g of the stage's span picks 0/2/1/3 times the in-group offset.
  function automatic logic [NLOG2-1:0] tw_exp(input logic [NLOG2-1:0] c, input int s);
    int b, m, g, n3, f;
    b  = NLOG2 - 2 * s;
    m  = int'(c) % (1 << b);
    g  = m >> (b - 2);
    n3 = m % (1 << (b - 2));
    case (g)
      0:       f = 0;
      1:       f = 2;
      2:       f = 1;
      default: f = 3;
    endcase
    return NLOG2'((n3 * f) << (2 * s));
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_to_drain  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (ctl.start_i && ctl.valid_i) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
        end
      end
      S_RUN: begin
        if (!ctl.valid_i) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (r_ctr == CTR_MAX && ctl.last_i) begin
          w_state_nxt = S_DRAIN;
          w_to_drain  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_active_nxt    = (w_state_nxt != S_IDLE);
    w_ctr_nxt       = (w_active_nxt && !w_start) ? r_ctr + 1'b1 : '0;
    w_lat_cnt_nxt   = w_start ? LAT_LOAD :
                      (r_lat_cnt != '0) ? r_lat_cnt - 1'b1 : r_lat_cnt;
    w_drain_cnt_nxt = w_to_drain ? DRAIN_LOAD :
                      (r_state == S_DRAIN && r_drain_cnt != '0) ? r_drain_cnt - 1'b1 : r_drain_cnt;
    w_valid_nxt     = w_active_nxt && (w_lat_cnt_nxt == '0);
    w_k_nxt         = w_start ? '0 : (r_valid ? r_k + 1'b1 : r_k);
    w_err_nxt       = r_err | w_abort;
    w_dp_rst_n_nxt  = ~w_abort;
  end

  // Selects and addresses are built from the next counter value so the registered copies line up with r_ctr.
  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    localparam int B = NLOG2 - 2 * s;
    localparam logic [NLOG2-1:0] OFF = NLOG2'((s * TW_LAT) % N);
    logic [B-1:0] w_cs;
    assign w_cs          = B'(w_ctr_nxt - OFF);
    assign w_bfi_nxt[s]  = w_active_nxt &  w_cs[B-1];
    assign w_bfii_nxt[s] = w_active_nxt &  w_cs[B-2];
    assign w_tsel_nxt[s] = w_active_nxt & ~w_cs[B-1];
    if (s < NSTAGE - 1) begin : g_tw
      assign w_tw_nxt[s*NLOG2 +: NLOG2] = w_active_nxt ? tw_exp(NLOG2'(w_cs), s) : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ctr       <= '0;
      r_lat_cnt   <= '0;
      r_drain_cnt <= '0;
      r_k         <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_dp_rst_n  <= 1'b0;
      r_bfi       <= '0;
      r_bfii      <= '0;
      r_tsel      <= '0;
      r_tw        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ctr       <= w_ctr_nxt;
      r_lat_cnt   <= w_lat_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_k         <= w_k_nxt;
      r_valid     <= w_valid_nxt;
      r_err       <= w_err_nxt;
      r_dp_rst_n  <= w_dp_rst_n_nxt;
      r_bfi       <= w_bfi_nxt;
      r_bfii      <= w_bfii_nxt;
      r_tsel      <= w_tsel_nxt;
      r_tw        <= w_tw_nxt;
    end
  end

`ifdef FFT_R22SDF_CTRL_BITREV_EN
  always_comb begin
    w_index = '0;
    for (int i = 0; i < NLOG2; i++) w_index[i] = r_k[NLOG2-1-i];
  end
`else
  assign w_index = r_k;
`endif

  assign ctl.dp_rst_n_o    = r_dp_rst_n;
  assign ctl.bfi_sel_o     = r_bfi;
  assign ctl.bfii_sel_o    = r_bfii;
  assign ctl.bfii_tsel_o   = r_tsel;
  assign ctl.tw_addr_o     = r_tw;
  assign ctl.dp_din_zero_o = (r_state == S_DRAIN);
  assign ctl.valid_o       = r_valid;
  assign ctl.index_o       = r_valid ? w_index : '0;
  assign ctl.busy_o        = (r_state != S_IDLE);
  assign ctl.err_o         = r_err;

endmodule
